// File: rtl/ssd1331_spi_arbiter_pkg.sv
// Shared types and constants for the SSD1331 MOSI-buffer arbiter.
// Holds the arbiter state encoding, the length field width and the default BUSY timeout.
package ssd1331_spi_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_BUSY,
        S_DONE,
        S_REJECT
    } state_t;

    localparam int LEN_W           = 5;
    localparam int TIMEOUT_DEFAULT = 4096;

    // A burst length is usable only if it is non-zero and fits the buffer depth.
    function automatic logic lenValid(input logic [LEN_W-1:0] len, input int depth);
        return (len != '0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/ssd1331_rr_picker.sv
// Combinational round-robin select: the first asserted request after i_ptr wins.
// The search wraps around, so i_ptr itself has the lowest priority.
module ssd1331_rr_picker
    import ssd1331_spi_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_valid,
    output logic [IDXW-1:0] o_idx
);

    logic [IDXW-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_cand = IDXW'((int'(i_ptr) + off) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd1331_spi_arbiter.sv
// Round-robin arbiter sharing one MOSI burst buffer between several requesters.
// Captures the granted payload, starts the buffer once and reports done/timeout back.
module ssd1331_spi_arbiter
    import ssd1331_spi_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N       = 8,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      i_SCK,
    input  logic                      i_RST_N,
    input  logic [NREQ-1:0]           i_REQ,
    input  logic [NREQ*WIDTH*N-1:0]   i_REQ_DATA,
    input  logic [NREQ*N-1:0]         i_REQ_DC,
    input  logic [NREQ*LEN_W-1:0]     i_REQ_LEN,
    output logic [NREQ-1:0]           o_ACK,
    output logic [NREQ-1:0]           o_GNT,
    output logic [NREQ-1:0]           o_DONE,
    output logic                      o_ERR,
    output logic [WIDTH*N-1:0]        o_BUF_DATA,
    output logic [N-1:0]              o_BUF_DC,
    output logic [LEN_W-1:0]          o_BUF_N_TRANSMIT,
    output logic                      o_BUF_START,
    input  logic                      i_BUF_FINAL_BYTE,
    input  logic                      i_MOSI_FINAL_BIT
);

    localparam int IDXW  = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int PW    = WIDTH * N;

    state_t           r_state;
    state_t           w_stateNext;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  w_idx;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  w_pick;
    logic [NREQ-1:0]  w_idxOneHot;
    logic             w_valid;
    logic             w_lenOk;
    logic             w_complete;
    logic             w_timeout;
    logic             r_err;
    logic [LEN_W-1:0] w_len;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [PW-1:0]    r_bufData;
    logic [N-1:0]     r_bufDc;
    logic [LEN_W-1:0] r_bufLen;

    ssd1331_rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .i_req   (i_REQ),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_len       = i_REQ_LEN[int'(w_idx)*LEN_W +: LEN_W];
    assign w_lenOk     = lenValid(w_len, N);
    assign w_complete  = i_BUF_FINAL_BYTE & i_MOSI_FINAL_BIT;
    assign w_cntNext   = r_cnt + 1'b1;
    assign w_idxOneHot = NREQ'(1) << r_idx;

    // ACK is raised in the IDLE cycle itself so the buffer can start two cycles later;
    // it is masked by reset so a held request cannot leak out while the block is held in reset.
    assign o_ACK            = (r_state == S_IDLE && w_valid && i_RST_N) ? w_pick : '0;
    assign o_GNT            = r_gnt;
    assign o_DONE           = (r_state == S_DONE || r_state == S_REJECT) ? w_idxOneHot : '0;
    assign o_ERR            = (r_state == S_REJECT) || (r_state == S_DONE && r_err);
    assign o_BUF_START      = (r_state == S_START) && !i_BUF_FINAL_BYTE;
    assign o_BUF_DATA       = r_bufData;
    assign o_BUF_DC         = r_bufDc;
    assign o_BUF_N_TRANSMIT = r_bufLen;

    always_ff @(posedge i_SCK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Completion is checked before the timeout so a coincident finish is never flagged.
    always_comb begin
        w_stateNext = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_stateNext = w_lenOk ? S_CAPTURE : S_REJECT;
                end
            end
            S_CAPTURE: w_stateNext = S_START;
            S_START: begin
                if (!i_BUF_FINAL_BYTE) begin
                    w_stateNext = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_complete) begin
                    w_stateNext = S_DONE;
                end else if (w_cntNext == CNT_W'(TIMEOUT - 1)) begin
                    w_stateNext = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            S_DONE:   w_stateNext = S_IDLE;
            S_REJECT: w_stateNext = S_IDLE;
            default:  w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge i_SCK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_gnt     <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_bufData <= '0;
            r_bufDc   <= '0;
            r_bufLen  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_idx <= w_idx;
                        if (w_lenOk) begin
                            r_gnt     <= w_pick;
                            r_bufData <= i_REQ_DATA[int'(w_idx)*PW +: PW];
                            r_bufDc   <= i_REQ_DC[int'(w_idx)*N +: N];
                            r_bufLen  <= w_len;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= w_cntNext;
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_ptr <= r_idx;
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    r_gnt <= '0;
                end
                S_REJECT: r_ptr <= r_idx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1331_spi_arbiter.sv
// Self-checking bench for ssd1331_spi_arbiter: vector table plus hand-written corner sequences.
// Completions are predicted into a queue when requests are driven and matched when o_DONE fires.
module tb_ssd1331_spi_arbiter;

    localparam int WIDTH   = 8;
    localparam int N       = 8;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 4096;
    localparam int PW      = WIDTH * N;

    typedef struct {
        int             k;
        logic [4:0]     len;
        logic [PW-1:0]  data;
        logic [N-1:0]   dc;
        bit             expErr;
    } vec_t;

    typedef struct {
        int         idx;
        logic       err;
        int         len;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rstN;
    logic [NREQ-1:0]         req;
    logic [NREQ*PW-1:0]      reqData;
    logic [NREQ*N-1:0]       reqDc;
    logic [NREQ*5-1:0]       reqLen;
    logic [NREQ-1:0]         ack;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic                    err;
    logic [PW-1:0]           bufData;
    logic [N-1:0]            bufDc;
    logic [4:0]              bufN;
    logic                    bufStart;
    logic                    finalByte;
    logic                    finalBit;

    int   checks = 0;
    int   errors = 0;
    exp_t doneQ[$];
    exp_t monExp;
    vec_t vecs[7];

    always #5 clk = ~clk;

    ssd1331_spi_arbiter #(
        .WIDTH   (WIDTH),
        .N       (N),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_SCK            (clk),
        .i_RST_N          (rstN),
        .i_REQ            (req),
        .i_REQ_DATA       (reqData),
        .i_REQ_DC         (reqDc),
        .i_REQ_LEN        (reqLen),
        .o_ACK            (ack),
        .o_GNT            (gnt),
        .o_DONE           (done),
        .o_ERR            (err),
        .o_BUF_DATA       (bufData),
        .o_BUF_DC         (bufDc),
        .o_BUF_N_TRANSMIT (bufN),
        .o_BUF_START      (bufStart),
        .i_BUF_FINAL_BYTE (finalByte),
        .i_MOSI_FINAL_BIT (finalBit)
    );

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s %s", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic [4:0] len, input logic [PW-1:0] data,
                                 input logic [N-1:0] dc);
        reqData[k*PW +: PW] = data;
        reqDc[k*N +: N]     = dc;
        reqLen[k*5 +: 5]    = len;
        req[k]              = 1'b1;
        #1;
    endtask

    task automatic waitAck(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < 32; c++) begin
            if (ack != '0) begin
                ok = 1'b1;
                for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
                break;
            end
            tick();
        end
        if (!ok) failNow("ackWait", "actual=no ack required=ack within 32 cycles");
    endtask

    // Counts cycles from the ACK cycle to the o_BUF_START cycle; optionally drops all requests.
    task automatic waitStart(input bit drop, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            lat++;
            if (c == 0 && drop) req = '0;
            if (bufStart) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("startWait", "actual=no start required=start within 40 cycles");
    endtask

    task automatic completeBurst(input int k);
        tick();
        checkOutput("startOneCycle", 64'(bufStart), 64'(0));
        finalByte = 1'b1;
        finalBit  = 1'b1;
        tick();
        finalByte = 1'b0;
        finalBit  = 1'b0;
        checkOutput("doneAt", 64'(done), 64'(onehot(k)));
        checkOutput("gntAtDone", 64'(gnt), 64'(onehot(k)));
        tick();
        checkOutput("gntCleared", 64'(gnt), 64'(0));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Ack"}, 64'(ack), 64'(0));
        checkOutput({tag, "Gnt"}, 64'(gnt), 64'(0));
        checkOutput({tag, "Done"}, 64'(done), 64'(0));
        checkOutput({tag, "Err"}, 64'(err), 64'(0));
        checkOutput({tag, "Start"}, 64'(bufStart), 64'(0));
        checkOutput({tag, "BufN"}, 64'(bufN), 64'(0));
        checkOutput({tag, "BufData"}, bufData, 64'(0));
        checkOutput({tag, "BufDc"}, 64'(bufDc), 64'(0));
    endtask

    task automatic runVector(input vec_t v);
        int idx;
        int lat;
        bit ok;
        doneQ.push_back('{v.k, v.expErr, int'(v.len)});
        applyStimulus(v.k, v.len, v.data, v.dc);
        waitAck(idx, ok);
        if (!ok) begin
            req = '0;
            doneQ.delete();
            tick();
            return;
        end
        checkOutput("ack", 64'(ack), 64'(onehot(v.k)));
        if (v.expErr) begin
            tick();
            req = '0;
            checkOutput("rejDone", 64'(done), 64'(onehot(v.k)));
            checkOutput("rejErr", 64'(err), 64'(1));
            checkOutput("rejNoStart", 64'(bufStart), 64'(0));
            checkOutput("rejGnt", 64'(gnt), 64'(0));
            tick();
            checkOutput("rejIdleNoStart", 64'(bufStart), 64'(0));
        end else begin
            waitStart(1'b1, lat, ok);
            if (!ok) return;
            checkOutput("startLat", 64'(lat), 64'(2));
            checkOutput("bufN", 64'(bufN), 64'(v.len));
            checkOutput("bufData", bufData, 64'(v.data));
            checkOutput("bufDc", 64'(bufDc), 64'(v.dc));
            completeBurst(v.k);
        end
    endtask

    // Scoreboard side: every start and done is matched against the oldest predicted burst.
    always @(negedge clk) begin
        if (rstN) begin
            if (!$onehot0(ack) || !$onehot0(gnt) || !$onehot0(done)) begin
                failNow("oneHot", $sformatf("actual ack=%b gnt=%b done=%b required=zero or one-hot", ack, gnt, done));
            end
            if (bufStart) begin
                if (doneQ.size() == 0) begin
                    failNow("startUnexpected", "actual=start required=no start");
                end else begin
                    checkOutput("sbStartGnt", 64'(gnt), 64'(onehot(doneQ[0].idx)));
                    checkOutput("sbStartLen", 64'(bufN), 64'(doneQ[0].len));
                end
            end
            if (done != '0) begin
                if (doneQ.size() == 0) begin
                    failNow("doneUnexpected", $sformatf("actual done=%b required=none", done));
                end else begin
                    monExp = doneQ.pop_front();
                    checkOutput("sbDone", 64'(done), 64'(onehot(monExp.idx)));
                    checkOutput("sbErr", 64'(err), 64'(monExp.err));
                end
            end else if (err) begin
                failNow("errWithoutDone", "actual err=1 required=0");
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int lat;
        int rel;
        bit ok;
        bit sawEarly;
        int order[4];

        vecs[0] = '{0, 5'd3,  64'h0000_0000_00A2_A1A0, 8'h00, 1'b0};
        vecs[1] = '{2, 5'd0,  64'h0,                   8'h00, 1'b1};
        vecs[2] = '{2, 5'd9,  64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1};
        vecs[3] = '{1, 5'd8,  64'h0123_4567_89AB_CDEF, 8'hA5, 1'b0};
        vecs[4] = '{2, 5'd1,  64'h0000_0000_0000_0055, 8'h01, 1'b0};
        vecs[5] = '{0, 5'd31, 64'h1111_2222_3333_4444, 8'h0F, 1'b1};
        vecs[6] = '{0, 5'd7,  64'hFEDC_BA98_7654_3210, 8'h3C, 1'b0};
        order   = '{1, 2, 0, 1};

        rstN      = 1'b0;
        req       = '0;
        reqData   = '0;
        reqDc     = '0;
        reqLen    = '0;
        finalByte = 1'b0;
        finalBit  = 1'b0;
        repeat (3) tick();
        checkAllZero("rst");
        rstN = 1'b1;
        tick();

        $display("[TB] round-robin with all requesters held");
        for (int k = 0; k < NREQ; k++) applyStimulus(k, 5'd1, 64'(8'h10 + k), 8'(k));
        for (int g = 0; g < 4; g++) doneQ.push_back('{order[g], 1'b0, 1});
        for (int g = 0; g < 4; g++) begin
            waitAck(idx, ok);
            if (!ok) break;
            checkOutput("rrAck", 64'(ack), 64'(onehot(order[g])));
            waitStart(g == 3, lat, ok);
            if (!ok) break;
            checkOutput("rrData", bufData, 64'(8'h10 + order[g]));
            completeBurst(order[g]);
        end
        req = '0;
        doneQ.delete();
        tick();

        $display("[TB] vector table");
        for (int v = 0; v < 7; v++) runVector(vecs[v]);

        $display("[TB] back-pressure at START");
        doneQ.push_back('{0, 1'b0, 2});
        applyStimulus(0, 5'd2, 64'h0000_0000_0000_BBAA, 8'h02);
        waitAck(idx, ok);
        if (ok) begin
            tick();
            req       = '0;
            finalByte = 1'b1;
            sawEarly  = 1'b0;
            repeat (4) begin
                tick();
                if (bufStart) sawEarly = 1'b1;
            end
            tick();
            finalByte = 1'b0;
            #1;
            checkOutput("bpNoEarlyStart", 64'(sawEarly), 64'(0));
            checkOutput("bpStart", 64'(bufStart), 64'(1));
            completeBurst(0);
        end

        $display("[TB] timeout in BUSY");
        doneQ.push_back('{0, 1'b1, 4});
        applyStimulus(0, 5'd4, 64'h0000_0000_4433_2211, 8'h00);
        waitAck(idx, ok);
        if (ok) begin
            waitStart(1'b1, lat, ok);
            if (ok) begin
                tick();
                rel = 0;
                ok  = 1'b0;
                for (int c = 0; c < TIMEOUT + 64; c++) begin
                    if (done != '0) begin
                        ok = 1'b1;
                        break;
                    end
                    tick();
                    rel++;
                end
                checkOutput("toCycle", 64'(rel), 64'(TIMEOUT - 1));
                checkOutput("toDone", 64'(done), 64'(onehot(0)));
                checkOutput("toErr", 64'(err), 64'(1));
                tick();
            end
        end
        runVector('{1, 5'd2, 64'h0000_0000_0000_7766, 8'h01, 1'b0});

        $display("[TB] reset in the middle of BUSY");
        doneQ.push_back('{2, 1'b0, 3});
        applyStimulus(2, 5'd3, 64'h0000_0000_00CC_BBAA, 8'h05);
        waitAck(idx, ok);
        if (ok) begin
            waitStart(1'b1, lat, ok);
            tick();
            tick();
        end
        rstN = 1'b0;
        #1;
        checkAllZero("midRst");
        doneQ.delete();
        tick();
        rstN = 1'b1;
        tick();
        for (int k = 0; k < NREQ; k++) applyStimulus(k, 5'd1, 64'(8'h20 + k), 8'h00);
        doneQ.push_back('{1, 1'b0, 1});
        waitAck(idx, ok);
        if (ok) begin
            checkOutput("postRstAck", 64'(ack), 64'(onehot(1)));
            waitStart(1'b1, lat, ok);
            if (ok) begin
                checkOutput("postRstLat", 64'(lat), 64'(2));
                checkOutput("postRstData", bufData, 64'(8'h21));
                completeBurst(1);
            end
        end
        req = '0;

        repeat (4) tick();
        checkOutput("sbDrained", 64'(doneQ.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd1331_spi_arbiter.md
Name: ssd1331_spi_arbiter

Overview:
Shares one Nbit MOSI SPI buffer between NREQ requesters, for example the init sequencer, pixel writer and scroll/config controller.
- Accepts a byte-burst request from each requester and grants it round-robin.
- Captures the granted payload, launches the buffer with a single start pulse, and waits for the last byte to leave MOSI.
- Reports completion or a timeout back to the granted requester.
- Sits between the OLED command/draw logic and the MOSI buffer, on the SPI clock domain.

Parameters:
WIDTH, 8, bits per byte sent over MOSI.
N, 8, maximum bytes per burst; also the buffer depth.
NREQ, 3, number of requesters (2..8).
TIMEOUT, 4096, i_SCK cycles allowed in BUSY before abort.

Ports:
i_SCK  in  1  SPI-domain clock; all logic on posedge.
i_RST_N  in  1  asynchronous active-low reset.
i_REQ  in  NREQ  per-requester request level; held until its o_ACK bit.
i_REQ_DATA  in  NREQ*WIDTH*N  payload, requester k at slice k; byte 0 in the LSBs.
i_REQ_DC  in  NREQ*N  data/command bit per byte, per requester.
i_REQ_LEN  in  NREQ*5  byte count per requester; valid range 1..N.
o_ACK  out  NREQ  one-cycle one-hot pulse; the payload has been captured.
o_GNT  out  NREQ  one-hot grant, held from capture through DONE.
o_DONE  out  NREQ  one-cycle one-hot pulse when the burst ends.
o_ERR  out  1  one-cycle pulse, coincident with o_DONE, on timeout or invalid length.
o_BUF_DATA  out  WIDTH*N  captured payload to the buffer.
o_BUF_DC  out  N  captured D/C bits to the buffer.
o_BUF_N_TRANSMIT  out  5  captured length to the buffer.
o_BUF_START  out  1  start pulse to the buffer.
i_BUF_FINAL_BYTE  in  1  buffer final-byte flag.
i_MOSI_FINAL_BIT  in  1  MOSI shifter final-bit flag.

Behaviour:
- Reset (async, i_RST_N=0): state IDLE, round-robin pointer 0, timeout counter 0; every output 0, including the o_BUF_* payload registers.
- States:
  - IDLE → CAPTURE, or IDLE → REJECT.
  - CAPTURE → START → BUSY → DONE → IDLE.
  - REJECT → IDLE.
- IDLE: scan i_REQ starting at pointer+1 (mod NREQ), wrapping; the first asserted index wins.
  - Valid length (1..N): latch that requester's DATA/DC/LEN into the o_BUF_* registers, set o_GNT, pulse o_ACK. Next state CAPTURE.
  - Invalid length (0 or >N): pulse o_ACK, latch the index. Next state REJECT.
- REJECT: o_DONE pulse and o_ERR pulse for that index, then IDLE. The buffer is never started; the pointer advances to the index.
- CAPTURE: one cycle; payload stable. Next state START.
- START: wait while i_BUF_FINAL_BYTE=1 (the buffer is still draining a prior burst).
  - When i_BUF_FINAL_BYTE=0, assert o_BUF_START for exactly one cycle; next state BUSY.
  - o_BUF_START is never high outside START.
- BUSY: o_BUF_START=0; the timeout counter increments every cycle.
  - Completion (i_BUF_FINAL_BYTE=1 and i_MOSI_FINAL_BIT=1 in the same cycle) → DONE, no error.
  - Counter reaching TIMEOUT-1 without completion → DONE with the error flag set.
  - Both in the same cycle: completion wins, no error.
- DONE: o_DONE pulse for the granted index, o_ERR = error flag. o_GNT clears on exit.
  - Pointer := granted index, counter := 0, error flag := 0. Next state IDLE.
- Payload registers hold their value after DONE (no clear).
- Latency from request to o_BUF_START: 2 cycles minimum (ACK in the IDLE→CAPTURE cycle, START two cycles later).
- Minimum gap between bursts: 3 cycles after completion.
- A request that drops before being granted is simply skipped; no error.
- Requests arriving during CAPTURE/START/BUSY/DONE wait; they are never lost while held.
- The pointer wraps NREQ-1 → 0.
- Only one grant is outstanding at any time; o_GNT, o_ACK and o_DONE are always zero or one-hot.
- Reset mid-burst: all state clears immediately. The buffer is reset by the same net, so no partial-burst recovery is required.

Decomposition:
- Shared package holds:
  - state encodings IDLE/CAPTURE/START/BUSY/DONE/REJECT;
  - the 5-bit length width constant;
  - the TIMEOUT default.
- One natural sub-module: ssd1331_rr_picker, a combinational round-robin one-hot select from a request vector and a pointer.
- The payload mux, FSM and timeout counter stay in this module.

Test Plan:
1. Single request: i_REQ=3'b001, LEN=3, DATA bytes A0,A1,A2, DC=000 → o_ACK[0] pulse; o_BUF_START 1 cycle, 2 cycles after ACK; o_BUF_N_TRANSMIT=3; o_DONE[0] after completion; o_ERR=0.
2. Round-robin: i_REQ=3'b111 held, each LEN=1 → grant order 1, 2, 0, 1 (pointer starts 0); each o_ACK one-hot; no overlap between o_GNT and the o_BUF_START of different requesters.
3. Invalid length: requester 2 LEN=0, then LEN=9 → o_ACK[2] then o_DONE[2] with o_ERR=1 each time; o_BUF_START stays 0.
4. Timeout: grant requester 0 and never assert i_MOSI_FINAL_BIT → o_DONE[0] and o_ERR exactly at BUSY cycle 4095; the next request is served normally.
5. Back-pressure: i_BUF_FINAL_BYTE held 1 for 5 cycles at START → o_BUF_START delayed until it falls, then exactly 1 cycle high.
6. Reset mid-BUSY: drop i_RST_N for 1 cycle → every output 0 immediately; the next request grants from pointer 0 (requester 1 first if all are requesting).
